// File: rtl/fde_pkg.sv
// rtl/fde_pkg.sv - shared opcode, field-position and destination-select definitions
package fde_pkg;

    localparam int NOPS = 16;
    localparam int RA   = 5;

    localparam int OPC_LSB = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int IMM_W   = 16;

    localparam logic [5:0] OP_ADD = 6'd0;
    localparam logic [5:0] OP_SUB = 6'd1;
    localparam logic [5:0] OP_LI  = 6'd2;
    localparam logic [5:0] OP_SLL = 6'd3;
    localparam logic [5:0] OP_SRL = 6'd4;
    localparam logic [5:0] OP_AND = 6'd5;
    localparam logic [5:0] OP_OR  = 6'd6;
    localparam logic [5:0] OP_XOR = 6'd7;
    localparam logic [5:0] OP_BR  = 6'd8;
    localparam logic [5:0] OP_BNE = 6'd9;
    localparam logic [5:0] OP_MOV = 6'd10;
    localparam logic [5:0] OP_ADI = 6'd11;
    localparam logic [5:0] OP_MUL = 6'd12;
    localparam logic [5:0] OP_HLT = 6'd13;
    localparam logic [5:0] OP_NOP = 6'd14;

    typedef struct packed {
        logic wen;
        logic use_rt;
    } dest_sel_t;

    // Immediate-form writers target rt, register-form writers target rd.
    function automatic dest_sel_t dest_sel(input logic [5:0] opc);
        dest_sel_t r;
        r.wen    = 1'b0;
        r.use_rt = 1'b0;
        case (opc)
            OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_AND,
            OP_OR, OP_XOR, OP_MOV, OP_MUL: r.wen = 1'b1;
            OP_LI, OP_ADI: begin
                r.wen    = 1'b1;
                r.use_rt = 1'b1;
            end
            OP_BR, OP_BNE, OP_HLT, OP_NOP: r.wen = 1'b0;
            default: r.wen = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// rtl/id_regfile.sv - register file, one write port, two write-first read ports
module id_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   wr_en_i,
    input  logic [fde_pkg::RA-1:0] wr_addr_i,
    input  logic [XLEN-1:0]        wr_data_i,
    input  logic [fde_pkg::RA-1:0] rd_addr_a_i,
    output logic [XLEN-1:0]        rd_data_a_o,
    input  logic [fde_pkg::RA-1:0] rd_addr_b_i,
    output logic [XLEN-1:0]        rd_data_b_o
);

    logic [XLEN-1:0] mem_q [NREG];

    // Storage: whole array clears on reset, r0 is an ordinary writable register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_a_o = (wr_en_i && wr_addr_i == rd_addr_a_i) ? wr_data_i : mem_q[rd_addr_a_i];
    assign rd_data_b_o = (wr_en_i && wr_addr_i == rd_addr_b_i) ? wr_data_i : mem_q[rd_addr_b_i];

endmodule

// File: rtl/id_stage_decoder.sv
// rtl/id_stage_decoder.sv - decode stage with scoreboard, halt and registered output packet
module id_stage_decoder #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NOPS = fde_pkg::NOPS
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   if_valid,
    output logic                   if_ready,
    input  logic [31:0]            if_instr,
    input  logic [XLEN-1:0]        if_pc,
    input  logic                   wb_en,
    input  logic [fde_pkg::RA-1:0] wb_addr,
    input  logic [XLEN-1:0]        wb_data,
    output logic                   ex_valid,
    input  logic                   ex_ready,
    output logic [31:0]            ex_instr,
    output logic [XLEN-1:0]        ex_pc,
    output logic [XLEN-1:0]        ex_rs_val,
    output logic [XLEN-1:0]        ex_rt_val,
    output logic [XLEN-1:0]        ex_imm,
    output logic [NOPS-1:0]        ex_op,
    output logic [fde_pkg::RA-1:0] ex_dest,
    output logic                   ex_wen,
    output logic                   ex_illegal,
    output logic                   halted
);
    import fde_pkg::*;

    logic [5:0]      opcode;
    logic [RA-1:0]   rs, rt, rd;
    logic [XLEN-1:0] rs_val, rt_val;

    assign opcode = if_instr[OPC_LSB +: 6];
    assign rs     = if_instr[RS_LSB +: RA];
    assign rt     = if_instr[RT_LSB +: RA];
    assign rd     = if_instr[RD_LSB +: RA];

    id_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clock       (clock),
        .reset_n     (reset_n),
        .wr_en_i     (wb_en),
        .wr_addr_i   (wb_addr),
        .wr_data_i   (wb_data),
        .rd_addr_a_i (rs),
        .rd_data_a_o (rs_val),
        .rd_addr_b_i (rt),
        .rd_data_b_o (rt_val)
    );

    // Decoded fields for the instruction currently offered by fetch.
    dest_sel_t       dsel;
    logic            illegal_d, wen_d;
    logic [RA-1:0]   dest_d;
    logic [NOPS-1:0] op_d;
    logic [XLEN-1:0] imm_d;

    assign dsel      = dest_sel(opcode);
    assign illegal_d = (opcode > OP_NOP);
    assign wen_d     = !illegal_d && dsel.wen;
    assign dest_d    = wen_d ? (dsel.use_rt ? rt : rd) : '0;
    assign op_d      = illegal_d ? '0 : ({{(NOPS-1){1'b0}}, 1'b1} << opcode);
    assign imm_d     = {{(XLEN-IMM_W){if_instr[IMM_W-1]}}, if_instr[IMM_W-1:0]};

    // Scoreboard: a write-back clears first, so the hazard check sees the freed register.
    logic [NREG-1:0] pending_q, pending_d, wb_clr, acc_set, pending_live;
    logic            hazard, accept, ex_valid_q, halted_q;

    assign wb_clr       = wb_en ? ({{(NREG-1){1'b0}}, 1'b1} << wb_addr) : '0;
    assign pending_live = pending_q & ~wb_clr;
    assign hazard       = pending_live[rs] | pending_live[rt];
    assign if_ready     = !halted_q && !hazard && (!ex_valid_q || ex_ready);
    assign accept       = if_valid && if_ready;
    assign acc_set      = (accept && wen_d) ? ({{(NREG-1){1'b0}}, 1'b1} << dest_d) : '0;
    assign pending_d    = pending_live | acc_set;

    // Pending bits and the sticky halt flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (accept && opcode == OP_HLT) begin
                halted_q <= 1'b1;
            end
        end
    end

    logic [31:0]     ex_instr_q;
    logic [XLEN-1:0] ex_pc_q, ex_rs_val_q, ex_rt_val_q, ex_imm_q;
    logic [NOPS-1:0] ex_op_q;
    logic [RA-1:0]   ex_dest_q;
    logic            ex_wen_q, ex_illegal_q;

    // Output packet: load on accept, drop valid once consumed, otherwise hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q   <= 1'b0;
            ex_instr_q   <= '0;
            ex_pc_q      <= '0;
            ex_rs_val_q  <= '0;
            ex_rt_val_q  <= '0;
            ex_imm_q     <= '0;
            ex_op_q      <= '0;
            ex_dest_q    <= '0;
            ex_wen_q     <= 1'b0;
            ex_illegal_q <= 1'b0;
        end else if (accept) begin
            ex_valid_q   <= 1'b1;
            ex_instr_q   <= if_instr;
            ex_pc_q      <= if_pc;
            ex_rs_val_q  <= rs_val;
            ex_rt_val_q  <= rt_val;
            ex_imm_q     <= imm_d;
            ex_op_q      <= op_d;
            ex_dest_q    <= dest_d;
            ex_wen_q     <= wen_d;
            ex_illegal_q <= illegal_d;
        end else if (ex_ready) begin
            ex_valid_q   <= 1'b0;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_instr   = ex_instr_q;
    assign ex_pc      = ex_pc_q;
    assign ex_rs_val  = ex_rs_val_q;
    assign ex_rt_val  = ex_rt_val_q;
    assign ex_imm     = ex_imm_q;
    assign ex_op      = ex_op_q;
    assign ex_dest    = ex_dest_q;
    assign ex_wen     = ex_wen_q;
    assign ex_illegal = ex_illegal_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_id_stage_decoder.sv
// tb/tb_id_stage_decoder.sv - directed self-checking bench for id_stage_decoder
module tb_id_stage_decoder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        if_valid, if_ready;
    logic [31:0] if_instr, if_pc;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_instr, ex_pc, ex_rs_val, ex_rt_val, ex_imm;
    logic [15:0] ex_op;
    logic [4:0]  ex_dest;
    logic        ex_wen, ex_illegal, halted;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clock = ~clock;

    id_stage_decoder dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_instr   (ex_instr),
        .ex_pc      (ex_pc),
        .ex_rs_val  (ex_rs_val),
        .ex_rt_val  (ex_rt_val),
        .ex_imm     (ex_imm),
        .ex_op      (ex_op),
        .ex_dest    (ex_dest),
        .ex_wen     (ex_wen),
        .ex_illegal (ex_illegal),
        .halted     (halted)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [4:0] d);
        return {op, s, t, d, 11'b0};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_en   = en;
        wb_addr = a;
        wb_data = d;
    endtask

    task automatic fetch(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
    endtask

    initial begin
        reset_n  = 1'b0;
        ex_ready = 1'b1;
        fetch(1'b0, 32'h0, 32'h0);
        wb(1'b0, 5'd0, 32'h0);
        tick();
        tick();
        check("rst_ex_valid", ex_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_ex_wen", ex_wen, 0);
        check("rst_ex_illegal", ex_illegal, 0);
        check("rst_ex_op", ex_op, 0);
        check("rst_ex_rs_val", ex_rs_val, 0);
        reset_n = 1'b1;

        // write-back r1=1, r2=2, then ADD r15 = r1 + r2
        wb(1'b1, 5'd1, 32'd1);
        tick();
        wb(1'b1, 5'd2, 32'd2);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        fetch(1'b1, r_ins(6'd0, 5'd1, 5'd2, 5'd15), 32'h100);
        #1 check("add_if_ready", if_ready, 1);
        tick();
        fetch(1'b0, 32'h0, 32'h0);
        check("add_ex_valid", ex_valid, 1);
        check("add_ex_op", ex_op, 16'h0001);
        check("add_rs_val", ex_rs_val, 1);
        check("add_rt_val", ex_rt_val, 2);
        check("add_dest", ex_dest, 15);
        check("add_wen", ex_wen, 1);
        check("add_pc", ex_pc, 32'h100);
        check("add_instr", ex_instr, r_ins(6'd0, 5'd1, 5'd2, 5'd15));

        // ADD r3, then dependent SUB stalls until WB r3 in the same cycle
        fetch(1'b1, r_ins(6'd0, 5'd1, 5'd2, 5'd3), 32'h104);
        tick();
        check("add3_dest", ex_dest, 3);
        fetch(1'b1, r_ins(6'd1, 5'd3, 5'd1, 5'd5), 32'h108);
        #1 check("sub_stall0", if_ready, 0);
        tick();
        check("sub_stall1", if_ready, 0);
        check("drain_valid", ex_valid, 0);
        wb(1'b1, 5'd3, 32'h55);
        #1 check("sub_wb_ready", if_ready, 1);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        fetch(1'b0, 32'h0, 32'h0);
        check("sub_ex_op", ex_op, 16'h0002);
        check("sub_rs_bypass", ex_rs_val, 32'h55);
        check("sub_rt_val", ex_rt_val, 1);
        check("sub_dest", ex_dest, 5);

        // LI with negative immediate, dest = rt
        fetch(1'b1, i_ins(6'd2, 5'd0, 5'd4, 16'h8000), 32'h10C);
        tick();
        check("li_imm", ex_imm, 32'hFFFF8000);
        check("li_dest", ex_dest, 4);
        check("li_op", ex_op, 16'h0004);
        check("li_wen", ex_wen, 1);

        // illegal opcode 0x3F with rd=6 must not mark r6 pending
        fetch(1'b1, r_ins(6'h3F, 5'd0, 5'd0, 5'd6), 32'h110);
        tick();
        check("ill_flag", ex_illegal, 1);
        check("ill_op", ex_op, 0);
        check("ill_wen", ex_wen, 0);
        check("ill_dest", ex_dest, 0);
        fetch(1'b1, r_ins(6'd10, 5'd6, 5'd0, 5'd7), 32'h114);
        #1 check("ill_no_pending", if_ready, 1);
        tick();
        check("mov_op", ex_op, 16'h0400);
        check("mov_illegal", ex_illegal, 0);
        check("mov_dest", ex_dest, 7);

        // back-pressure: hold three cycles, packet stays put, then XOR issues once
        ex_ready = 1'b0;
        fetch(1'b1, r_ins(6'd7, 5'd3, 5'd1, 5'd8), 32'h118);
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_if_ready", if_ready, 0);
            tick();
            check("hold_op", ex_op, 16'h0400);
            check("hold_pc", ex_pc, 32'h114);
            check("hold_valid", ex_valid, 1);
        end
        ex_ready = 1'b1;
        #1 check("release_ready", if_ready, 1);
        tick();
        fetch(1'b0, 32'h0, 32'h0);
        check("xor_op", ex_op, 16'h0080);
        check("xor_rs_val", ex_rs_val, 32'h55);
        check("xor_pc", ex_pc, 32'h118);
        tick();
        check("xor_no_dup", ex_valid, 0);

        // set and clear of r9 in one cycle: set wins, OR r9 stalls until next WB
        wb(1'b1, 5'd9, 32'h77);
        fetch(1'b1, r_ins(6'd0, 5'd1, 5'd2, 5'd9), 32'h11C);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        fetch(1'b1, r_ins(6'd6, 5'd9, 5'd1, 5'd10), 32'h120);
        #1 check("setwins_stall", if_ready, 0);
        tick();
        wb(1'b1, 5'd9, 32'h99);
        #1 check("setwins_release", if_ready, 1);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        check("or_op", ex_op, 16'h0040);
        check("or_rs_bypass", ex_rs_val, 32'h99);

        // HLT then NOP: NOP never accepted, HLT drains
        fetch(1'b1, r_ins(6'd13, 5'd0, 5'd0, 5'd0), 32'h124);
        tick();
        check("hlt_halted", halted, 1);
        check("hlt_op", ex_op, 16'h2000);
        check("hlt_wen", ex_wen, 0);
        fetch(1'b1, r_ins(6'd14, 5'd0, 5'd0, 5'd0), 32'h128);
        #1 check("nop_blocked", if_ready, 0);
        tick();
        check("hlt_drained", ex_valid, 0);
        tick();
        check("nop_not_issued", ex_valid, 0);
        check("still_halted", halted, 1);

        // reset pulse clears halt, scoreboard and register file
        reset_n = 1'b0;
        #1;
        check("rst2_halted", halted, 0);
        check("rst2_ex_op", ex_op, 0);
        tick();
        reset_n = 1'b1;
        fetch(1'b1, r_ins(6'd6, 5'd10, 5'd3, 5'd2), 32'h200);
        #1 check("rst2_no_pending", if_ready, 1);
        tick();
        fetch(1'b0, 32'h0, 32'h0);
        check("rst2_op", ex_op, 16'h0040);
        check("rst2_rs_zero", ex_rs_val, 0);
        check("rst2_rt_zero", ex_rt_val, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_stage_decoder.md
# id_stage_decoder

Parametrised instruction-decode stage sitting between fetch and execute. It captures one instruction per accepted handshake. It reads two operands from an internal register file, with write-back bypass, sign-extends the immediate and emits a one-hot operation vector. Compared with the first-generation decoder, it adds:
- valid/ready flow control on both sides
- a register scoreboard that stalls read-after-write hazards
- illegal-opcode flagging
- a halt state entered on HLT

## Interface

Parameters:
- `XLEN`, 32: data and PC width.
- `NREG`, 32: register count; power of two; `RA = log2(NREG)`, fixed at 5 for the 32-bit encoding.
- `NOPS`, 16: one-hot operation vector width.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `if_valid` in 1: fetch presents an instruction.
- `if_ready` out 1: decode accepts this cycle.
- `if_instr` in 32: instruction word. Fields:
  - opcode [31:26]
  - rs [25:21]
  - rt [20:16]
  - rd [15:11]
  - imm [15:0]
- `if_pc` in XLEN: PC of the instruction.
- `wb_en` in 1: write-back strobe.
- `wb_addr` in RA: write-back register.
- `wb_data` in XLEN: write-back value.
- `ex_valid` out 1: decoded packet valid.
- `ex_ready` in 1: execute accepts the packet.
- `ex_instr` out 32, `ex_pc` out XLEN: pass-through of the instruction and PC.
- `ex_rs_val` out XLEN, `ex_rt_val` out XLEN: operand values.
- `ex_imm` out XLEN: imm[15:0] sign-extended to XLEN.
- `ex_op` out NOPS: one-hot operation.
- `ex_dest` out RA: destination register.
- `ex_wen` out 1: instruction writes a register.
- `ex_illegal` out 1: opcode is not in the table.
- `halted` out 1: HLT has been issued.

## Operation

- **Opcode table**, ex_op bit = opcode value:
  - 0 ADD, 1 SUB, 2 LI, 3 SLL, 4 SRL, 5 AND, 6 OR, 7 XOR
  - 8 BR, 9 BNE, 10 MOV, 11 ADI, 12 MUL, 13 HLT, 14 NOP
- **Illegal opcodes**: any opcode ≥15 gives `ex_op = 0` and `ex_illegal = 1`, with `ex_wen = 0`.
- **Destination**:
  - ADD–XOR, MOV, MUL: dest = rd, wen = 1.
  - LI, ADI: dest = rt, wen = 1.
  - BR, BNE, HLT, NOP: wen = 0, dest = 0.
- **Register file**:
  - NREG × XLEN; all entries reset to 0; every register is writable, including r0.
  - Write occurs on `wb_en`.
  - Read bypass: if `wb_en` and `wb_addr` equals the read address in the same cycle, the operand takes `wb_data`.
- **Scoreboard**: one pending bit per register.
  - Set for `ex_dest` when an instruction with `wen = 1` is accepted.
  - Cleared on `wb_en` for `wb_addr`.
  - Same register set and cleared in the same cycle: set wins.
- **Hazard**: `hazard = pending[rs] | pending[rt]`, evaluated after this cycle's write-back clear. A register cleared this cycle does not stall; its bypassed value is used.
- **Accept condition**: `if_ready = !halted & !hazard & (!ex_valid | ex_ready)`. An accept occurs when `if_valid & if_ready`.
- **Halt**: accepting HLT sets `halted`. `if_ready` then stays 0 until reset. Packets already issued still drain.
- **Output hold**: while `ex_valid & !ex_ready`, all `ex_*` outputs hold stable.

## Timing

- Latency: an instruction accepted at edge N appears on `ex_*` after edge N; one cycle.
- Throughput: one instruction per cycle when there are no hazards and `ex_ready = 1`.
- `ex_valid` falls after an edge where `ex_ready = 1` and no new accept occurs.
- `if_ready` is combinational from `if_instr`, scoreboard state, `wb_*`, `ex_valid`, `ex_ready` and `halted`. There is no combinational path from `if_valid`.
- Reset values, asynchronous on `reset_n` low:
  - `ex_valid`, `halted`, `ex_illegal`, `ex_wen` = 0
  - all `ex_*` data = 0
  - scoreboard clear; register file = 0
- Reset mid-stall or mid-packet discards the packet and all pending bits.
- Back-to-back dependent instructions: the second stalls until write-back of the first. It issues in the same cycle `wb_en` fires for that register.

## Structure

- Shared package `fde_pkg`:
  - opcode localparams
  - `NOPS`
  - field bit positions
  - dest-select and wen lookup function
- Sub-module `id_regfile`: NREG × XLEN storage with one write port, two read ports, write-first bypass and asynchronous clear.
- Top module holds the scoreboard, control, halt flag and output register.

## Test plan

- Reset, then fetch opcode 0 with rs=1, rt=2, rd=15 after prior WB r1=1, r2=2 → next cycle `ex_valid=1`, `ex_op=0x0001`, `ex_rs_val=1`, `ex_rt_val=2`, `ex_dest=15`, `ex_wen=1`.
- ADD rd=3, then SUB with rs=3 → `if_ready=0` until WB r3=0x55; in that WB cycle SUB is accepted and `ex_rs_val=0x55`.
- imm=0x8000 on LI → `ex_imm=0xFFFF8000`, `dest=rt`, `ex_op=0x0004`.
- Opcode 0x3F → `ex_illegal=1`, `ex_op=0`, `ex_wen=0`, and no scoreboard bit set.
- Hold `ex_ready=0` for 3 cycles with `if_valid=1` → outputs stable, `if_ready=0`, no instruction lost or duplicated.
- HLT followed by NOP → `halted=1`, NOP never accepted; `reset_n` pulse returns `halted=0` and the register file to 0.
